icache_dm: RTL and testbench
============================

# icache_dm

Direct-mapped, parametrised instruction cache that replaces the fixed combinational instruction ROM in front of the fetch stage. It serves 32-bit little-endian instruction words to the fetch stage. Misses are refilled one byte at a time from a byte-wide backing instruction memory through a req/ack handshake. Line count, line length and address width are parameters, and the cache supports a whole-cache flush.

## Interface
- ADDR_WIDTH, 16: byte address width.
- LINES, 8: number of lines; must be a power of two, ≥2.
- LINE_WORDS, 4: 32-bit words per line; must be a power of two, ≥1.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- fetch_req  in  1  fetch request; accepted when fetch_req && fetch_ready.
- fetch_addr  in  ADDR_WIDTH  byte address of the instruction.
- fetch_ready  out  1  cache can accept a request (state IDLE).
- fetch_valid  out  1  one-cycle pulse; fetch_data/fetch_err are valid.
- fetch_data  out  32  instruction word; byte at addr+3 is bits [31:24], byte at addr is bits [7:0].
- fetch_err  out  1  misaligned request; pulses together with fetch_valid.
- flush  in  1  clears all line valid bits.
- mem_req  out  1  backing-memory byte read request.
- mem_addr  out  ADDR_WIDTH  byte address being read.
- mem_ack  in  1  mem_rdata is valid this cycle; completes the request.
- mem_rdata  in  8  returned byte.
- stat_hits, stat_misses  out  32 each  present only with ICACHE_STATS_EN.

## Operation
- Address split, from LSB upward:
  - byte offset [1:0]
  - word offset, log2(LINE_WORDS) bits
  - index, log2(LINES) bits
  - tag, the remaining bits
- Storage per line: valid bit, tag, LINE_WORDS×32 data.
- FSM states are IDLE, REFILL and RESPOND.
- IDLE, request accepted:
  - Misaligned (addr[1:0]≠0): next cycle fetch_valid=1, fetch_err=1, fetch_data=0. No refill; stay IDLE.
  - Hit (valid && tag match): next cycle fetch_valid=1 with the word; stay IDLE. Back-to-back hits run at one per cycle.
  - Miss: capture the address and go to REFILL. Line base = address with offset bits zeroed.
- REFILL:
  - Exactly one outstanding byte request. mem_req=1 and mem_addr are held until mem_ack.
  - Each ack writes mem_rdata into the byte slot (mem_addr − line base).
  - mem_addr increments by 1 per ack, 4·LINE_WORDS bytes in total.
  - After the last ack: write the tag, set valid, go to RESPOND.
- RESPOND: fetch_valid=1 with the requested word; then IDLE.
- flush:
  - Clears every valid bit at the clock edge.
  - During REFILL the refill still completes and the word is delivered, but the line is left invalid.
  - flush together with an accepted request in IDLE: the request is treated as a miss.
- fetch_req while fetch_ready=0 is ignored, not queued.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.

## Timing
- Reset values:
  - fetch_valid, fetch_err, mem_req = 0
  - fetch_data, mem_addr = 0
  - fetch_ready = 1
  - all valid bits = 0
  - state = IDLE
  - counters = 0
- Reset mid-refill: mem_req drops asynchronously and the partial line stays invalid.
- Hit latency: 1 cycle from acceptance to fetch_valid.
- Miss latency: 1 cycle to enter REFILL, then the ack cycles, then 1 RESPOND cycle.
- A zero-wait memory (mem_ack in the same cycle as mem_req) is legal: 4·LINE_WORDS cycles of REFILL.
- mem_ack while mem_req=0 is ignored.

## Configuration
- ICACHE_STATS_EN defined:
  - stat_hits counts accepted aligned hits.
  - stat_misses counts accepted aligned misses.
  - Both wrap at 2^32, and neither counts misaligned requests.
- ICACHE_STATS_EN undefined: the ports and counters do not exist.

## Structure
- Package icache_pkg holds:
  - the state enum (IDLE, REFILL, RESPOND)
  - BYTE=8, WORD=32, WORD_BYTES=4
  - field-width helper functions
- Sub-module icache_refill: the byte-serial refill engine. It owns mem_req/mem_addr, the byte counter and the byte-write strobes, and signals done to the top FSM.

## Test plan
Bench parameters: LINES=8, LINE_WORDS=4, ADDR_WIDTH=16.
- Cold fetch:
  - Stimulus: fetch 0x0000; backing bytes at 0x0000–0x0003 are 01, 00, 21, E0.
  - Refill: mem_addr steps 0x0000→0x000F with 16 acks; fetch_data=0xE0210001.
  - Follow-up: fetch 0x0004 hits on the next cycle with mem_req staying 0.
- Conflict miss: fetch 0x0000, then 0x0080 (same index, new tag) → refill from 0x0080. Then 0x0000 misses and refills again.
- Misaligned: fetch 0x0002 → next cycle fetch_valid=1, fetch_err=1, fetch_data=0; mem_req never rises.
- Flush mid-refill: flush at the 7th ack while fetching 0x0010 → word still delivered; a refetch of 0x0010 misses.
- Reset mid-refill: rst_n low after 5 acks → mem_req=0 and fetch_ready=1 immediately. Refetch refills all 16 bytes starting at the line base.
- Statistics: with ICACHE_STATS_EN, 3 misses + 5 hits + 1 misaligned → stat_misses=3, stat_hits=5.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types, constants and address-field width helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRefill,
    StRespond
  } state_e;

  localparam int unsigned BYTE       = 8;
  localparam int unsigned WORD       = 32;
  localparam int unsigned WORD_BYTES = 4;

  // Byte-offset-within-line width (byte offset plus word offset).
  function automatic int unsigned off_bits(input int unsigned line_words);
    return $clog2(line_words * WORD_BYTES);
  endfunction

  function automatic int unsigned idx_bits(input int unsigned lines);
    return $clog2(lines);
  endfunction

endpackage

// File: rtl/icache_refill.sv
// Byte-serial line refill engine: one outstanding byte read at a time over a req/ack handshake.
module icache_refill
  import icache_pkg::*;
#(
  parameter int unsigned AddrWidth = 16,
  parameter int unsigned LineWords = 4,
  localparam int unsigned OffW     = off_bits(LineWords)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] base_i,
  input  logic                 mem_ack_i,
  output logic                 mem_req_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic                 we_o,
  output logic [OffW-1:0]      wr_byte_o,
  output logic                 done_o
);

  logic                 busy_q, busy_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [OffW-1:0]      cnt_q, cnt_d;
  logic                 ack;

  // Acks with no request outstanding are dropped here.
  assign ack = busy_q & mem_ack_i;

  always_comb begin
    busy_d = busy_q;
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (start_i) begin
      busy_d = 1'b1;
      addr_d = base_i;
      cnt_d  = '0;
    end else if (ack) begin
      addr_d = addr_q + AddrWidth'(1);
      cnt_d  = cnt_q + OffW'(1);
      if (&cnt_q) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign mem_req_o  = busy_q;
  assign mem_addr_o = addr_q;
  assign we_o       = ack;
  assign wr_byte_o  = cnt_q;
  assign done_o     = ack & (&cnt_q);

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with byte-serial refill and whole-cache flush.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_dm
  import icache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LINES      = 8,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  fetch_req_i,
  input  logic [ADDR_WIDTH-1:0] fetch_addr_i,
  output logic                  fetch_ready_o,
  output logic                  fetch_valid_o,
  output logic [WORD-1:0]       fetch_data_o,
  output logic                  fetch_err_o,
  input  logic                  flush_i,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_ack_i,
  input  logic [BYTE-1:0]       mem_rdata_i
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]           stat_hits_o,
  output logic [31:0]           stat_misses_o
`endif
);

  localparam int unsigned OffW      = off_bits(LINE_WORDS);
  localparam int unsigned IdxW      = idx_bits(LINES);
  localparam int unsigned TagW      = ADDR_WIDTH - OffW - IdxW;
  localparam int unsigned LineBytes = LINE_WORDS * WORD_BYTES;

  logic [BYTE-1:0]      data_q [LINES][LineBytes];
  logic [TagW-1:0]      tag_q  [LINES];
  logic [LINES-1:0]     valid_q, valid_d;
  state_e               state_q, state_d;
  logic [OffW+IdxW-1:0] req_q, req_d;
  logic                 flushed_q, flushed_d;
  logic                 fetch_valid_q, fetch_valid_d;
  logic                 fetch_err_q, fetch_err_d;
  logic [WORD-1:0]      fetch_data_q, fetch_data_d;

  logic [IdxW-1:0]       in_idx, rq_idx;
  logic [TagW-1:0]       in_tag;
  logic [OffW-1:0]       in_off, rq_off, wr_byte;
  logic [ADDR_WIDTH-1:0] line_base;
  logic                  accept, misaligned, hit, miss_start, refill_we, refill_done;
  logic [WORD-1:0]       hit_word, refill_word;

  assign in_off     = fetch_addr_i[OffW-1:0];
  assign in_idx     = fetch_addr_i[OffW +: IdxW];
  assign in_tag     = fetch_addr_i[OffW+IdxW +: TagW];
  assign rq_off     = req_q[OffW-1:0];
  assign rq_idx     = req_q[OffW +: IdxW];
  assign line_base  = {fetch_addr_i[ADDR_WIDTH-1:OffW], {OffW{1'b0}}};
  assign accept     = fetch_req_i && (state_q == StIdle);
  assign misaligned = |fetch_addr_i[1:0];
  // A flush in the acceptance cycle forces the request down the miss path.
  assign hit        = valid_q[in_idx] && (tag_q[in_idx] == in_tag) && !flush_i;
  assign miss_start = accept && !misaligned && !hit;

  icache_refill #(
    .AddrWidth(ADDR_WIDTH),
    .LineWords(LINE_WORDS)
  ) u_refill (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (miss_start),
    .base_i    (line_base),
    .mem_ack_i (mem_ack_i),
    .mem_req_o (mem_req_o),
    .mem_addr_o(mem_addr_o),
    .we_o      (refill_we),
    .wr_byte_o (wr_byte),
    .done_o    (refill_done)
  );

  // The final byte of the line lands in the same cycle as done, so bypass it in.
  always_comb begin
    hit_word    = '0;
    refill_word = '0;
    for (int b = 0; b < WORD_BYTES; b++) begin
      hit_word[b*BYTE +: BYTE]    = data_q[in_idx][in_off + OffW'(b)];
      refill_word[b*BYTE +: BYTE] = (refill_we && (wr_byte == rq_off + OffW'(b))) ?
                                    mem_rdata_i : data_q[rq_idx][rq_off + OffW'(b)];
    end
  end

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    flushed_d     = flushed_q;
    fetch_valid_d = 1'b0;
    fetch_err_d   = 1'b0;
    fetch_data_d  = fetch_data_q;
    valid_d       = valid_q;
    if (flush_i) valid_d = '0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (misaligned) begin
            fetch_valid_d = 1'b1;
            fetch_err_d   = 1'b1;
            fetch_data_d  = '0;
          end else if (hit) begin
            fetch_valid_d = 1'b1;
            fetch_data_d  = hit_word;
          end else begin
            req_d           = fetch_addr_i[OffW+IdxW-1:0];
            flushed_d       = 1'b0;
            valid_d[in_idx] = 1'b0;
            state_d         = StRefill;
          end
        end
      end
      StRefill: begin
        if (flush_i) flushed_d = 1'b1;
        if (refill_done) begin
          fetch_valid_d = 1'b1;
          fetch_data_d  = refill_word;
          if (!flushed_q && !flush_i) valid_d[rq_idx] = 1'b1;
          state_d = StRespond;
        end
      end
      StRespond: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      req_q         <= '0;
      flushed_q     <= 1'b0;
      valid_q       <= '0;
      fetch_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      fetch_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      flushed_q     <= flushed_d;
      valid_q       <= valid_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_err_q   <= fetch_err_d;
      fetch_data_q  <= fetch_data_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (refill_we) data_q[rq_idx][wr_byte] <= mem_rdata_i;
    if (miss_start) tag_q[in_idx] <= in_tag;
  end

  assign fetch_ready_o = (state_q == StIdle);
  assign fetch_valid_o = fetch_valid_q;
  assign fetch_err_o   = fetch_err_q;
  assign fetch_data_o  = fetch_data_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hits_q, misses_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      if (accept && !misaligned && hit) hits_q <= hits_q + 32'd1;
      if (miss_start) misses_q <= misses_q + 32'd1;
    end
  end

  assign stat_hits_o   = hits_q;
  assign stat_misses_o = misses_q;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Scoreboard bench for icache_dm: reference cache model, random byte-memory responder,
// directed corner cases followed by randomized fetch traffic.
module tb_icache_dm;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_ready_o, fetch_valid_o, fetch_err_o;
  logic [31:0] fetch_data_o;
  logic        flush;
  logic        mem_req_o;
  logic [15:0] mem_addr_o;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
`ifdef ICACHE_STATS_EN
  logic [31:0] stat_hits_o, stat_misses_o;
  int          exp_hits = 0, exp_misses = 0;
`endif

  icache_dm #(
    .ADDR_WIDTH(16),
    .LINES     (8),
    .LINE_WORDS(4)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .fetch_req_i  (fetch_req),
    .fetch_addr_i (fetch_addr),
    .fetch_ready_o(fetch_ready_o),
    .fetch_valid_o(fetch_valid_o),
    .fetch_data_o (fetch_data_o),
    .fetch_err_o  (fetch_err_o),
    .flush_i      (flush),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ack_i    (mem_ack),
    .mem_rdata_i  (mem_rdata)
`ifdef ICACHE_STATS_EN
    ,
    .stat_hits_o  (stat_hits_o),
    .stat_misses_o(stat_misses_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  logic [7:0]  bmem [65536];
  bit          mvalid [8];
  logic [8:0]  mtag [8];
  logic [32:0] exp_q [$];
  logic [15:0] refill_q [$];
  int          n_chk = 0, n_pass = 0;
  bit          zero_wait = 0, active = 0, resp_flush = 0;
  int          cur_cnt = 0, flush_at_ack = 0;
  logic [15:0] cur_base = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp_v);
  endtask

  task automatic note_fail(input string name);
    n_chk++;
    $display("FAIL %s: unexpected event at %0t", name, $time);
  endtask

  function automatic logic [31:0] word_at(input logic [15:0] a);
    return {bmem[a + 16'd3], bmem[a + 16'd2], bmem[a + 16'd1], bmem[a]};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!fetch_ready_o && k < 200) begin
      @(negedge clk_i);
      k++;
    end
    if (!fetch_ready_o) note_fail("ready_timeout");
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic issue(input logic [15:0] a, input bit with_flush);
    logic [2:0] idx;
    logic [8:0] tg;
    bit aligned, hit;
    wait_ready();
    idx     = a[6:4];
    tg      = a[15:7];
    aligned = (a[1:0] == 2'b00);
    if (with_flush) clear_model();
    hit = aligned && mvalid[idx] && (mtag[idx] == tg);
    if (!aligned) begin
      exp_q.push_back({1'b1, 32'h0});
    end else begin
      exp_q.push_back({1'b0, word_at(a)});
      if (hit) begin
`ifdef ICACHE_STATS_EN
        exp_hits++;
`endif
      end else begin
`ifdef ICACHE_STATS_EN
        exp_misses++;
`endif
        refill_q.push_back({a[15:4], 4'h0});
        mvalid[idx] = 1'b1;
        mtag[idx]   = tg;
      end
    end
    fetch_addr = a;
    fetch_req  = 1'b1;
    if (with_flush) flush = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    fetch_req = 1'b0;
    if (with_flush) flush = 1'b0;
    if (!aligned || hit) begin
      chk(aligned ? "hit_latency" : "misaligned_latency", 32'(fetch_valid_o), 32'd1);
      chk(aligned ? "hit_no_mem_req" : "misaligned_no_mem_req", 32'(mem_req_o), 32'd0);
    end else begin
      chk("miss_enters_refill", 32'(mem_req_o), 32'd1);
      chk("miss_not_ready", 32'(fetch_ready_o), 32'd0);
    end
  endtask

  // Backing memory: random wait states (or zero-wait), occasional stray acks when idle.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    flush     = 1'b0;
    forever begin
      @(negedge clk_i);
      if (resp_flush) begin
        flush      = 1'b0;
        resp_flush = 1'b0;
      end
      mem_ack = 1'b0;
      if (!rst_ni) begin
        active  = 1'b0;
        cur_cnt = 0;
      end else if (mem_req_o) begin
        if (!active) begin
          if (refill_q.size() == 0) begin
            note_fail("unexpected_refill");
            cur_base = mem_addr_o;
          end else begin
            cur_base = refill_q.pop_front();
          end
          active  = 1'b1;
          cur_cnt = 0;
        end
        if (zero_wait || $urandom_range(0, 2) != 0) begin
          chk("refill_addr", 32'(mem_addr_o), 32'(16'(cur_base + 16'(cur_cnt))));
          mem_ack   = 1'b1;
          mem_rdata = bmem[mem_addr_o];
          cur_cnt++;
          if (flush_at_ack != 0 && cur_cnt == flush_at_ack) begin
            flush      = 1'b1;
            resp_flush = 1'b1;
            clear_model();
          end
          if (cur_cnt == 16) active = 1'b0;
        end
      end else begin
        if (active) begin
          note_fail("refill_short");
          active = 1'b0;
        end
        if ($urandom_range(0, 7) == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = 8'($urandom);
        end
      end
    end
  end

  // Monitor: every fetch_valid pulse must match the oldest expected response.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk_i);
      if (rst_ni && fetch_valid_o) begin
        if (exp_q.size() == 0) begin
          note_fail("unexpected_fetch_valid");
        end else begin
          e = exp_q.pop_front();
          chk("fetch_err", 32'(fetch_err_o), 32'(e[32]));
          chk("fetch_data", fetch_data_o, e[31:0]);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [15:0] a;
    rst_ni     = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    for (int i = 0; i < 65536; i++) bmem[i] = 8'($urandom);
    bmem[0] = 8'h01;
    bmem[1] = 8'h00;
    bmem[2] = 8'h21;
    bmem[3] = 8'hE0;
    clear_model();

    #2;
    chk("rst_fetch_valid", 32'(fetch_valid_o), 32'd0);
    chk("rst_fetch_err", 32'(fetch_err_o), 32'd0);
    chk("rst_fetch_data", fetch_data_o, 32'd0);
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr_o), 32'd0);
    chk("rst_fetch_ready", 32'(fetch_ready_o), 32'd1);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Cold fetch, then hits including back-to-back.
    chk("cold_word_model", word_at(16'h0000), 32'hE0210001);
    issue(16'h0000, 1'b0);
    issue(16'h0004, 1'b0);
    issue(16'h0008, 1'b0);
    issue(16'h000C, 1'b0);

    // Conflict misses; requests during refill must be ignored.
    issue(16'h0080, 1'b0);
    fetch_req  = 1'b1;
    fetch_addr = 16'h0042;
    repeat (3) @(negedge clk_i);
    fetch_req = 1'b0;
    issue(16'h0000, 1'b0);
    issue(16'h0002, 1'b0);

    // Flush on the 7th refill ack.
    flush_at_ack = 7;
    issue(16'h0010, 1'b0);
    wait_ready();
    flush_at_ack = 0;
    issue(16'h0010, 1'b0);
    issue(16'h0014, 1'b0);
    issue(16'h0014, 1'b1);

    // Reset after 5 acks.
    issue(16'h0020, 1'b0);
    k = 0;
    while (cur_cnt < 5 && k < 200) begin
      @(negedge clk_i);
      #1;
      k++;
    end
    if (cur_cnt < 5) note_fail("reset_ack_timeout");
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(mem_req_o), 32'd0);
    chk("midrst_fetch_ready", 32'(fetch_ready_o), 32'd1);
    active  = 1'b0;
    cur_cnt = 0;
    mem_ack = 1'b0;
    exp_q.delete();
    refill_q.delete();
    clear_model();
`ifdef ICACHE_STATS_EN
    exp_hits   = 0;
    exp_misses = 0;
`endif
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    issue(16'h0020, 1'b0);

    // Zero-wait memory and address-space top.
    zero_wait = 1'b1;
    issue(16'hFFFC, 1'b0);
    k = 0;
    while (!fetch_valid_o && k < 100) begin
      @(negedge clk_i);
      k++;
    end
    chk("zero_wait_latency", 32'(k), 32'd16);
    issue(16'hFFF0, 1'b0);
    zero_wait = 1'b0;

    // Random traffic over a few tags to force conflicts.
    for (int n = 0; n < 200; n++) begin
      zero_wait = ($urandom_range(0, 3) == 0);
      a[15:7] = ($urandom_range(0, 4) == 0) ? 9'h1FF : 9'($urandom_range(0, 3));
      a[6:2]  = 5'($urandom);
      a[1:0]  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      issue(a, $urandom_range(0, 15) == 0);
    end

    wait_ready();
    repeat (3) @(negedge clk_i);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("refills_consumed", 32'(refill_q.size()), 32'd0);
`ifdef ICACHE_STATS_EN
    chk("stat_hits", stat_hits_o, 32'(exp_hits));
    chk("stat_misses", stat_misses_o, 32'(exp_misses));
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
